// File: rtl/risc_sequencer_if.sv
// Control bundle between the VeriRISC sequencer and the datapath/memory it steers.
interface risc_sequencer_if;
    logic [2:0] opcode;
    logic       zero;
    logic       sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       ld_ir;
    logic       ld_ac;
    logic       ld_pc;
    logic       inc_pc;
    logic       data_e;
    logic       halt;
    logic [2:0] phase;

    modport master (
        input  opcode, zero,
        output sel, mem_rd, mem_wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, mem_rd, mem_wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
    );
endinterface

// File: rtl/risc_sequencer.sv
// Eight-phase fetch/execute sequencer: a phase counter plus halted flag,
// with control strobes decoded combinationally from phase, opcode and zero.
module risc_sequencer #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    risc_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_e state, state_nxt;
    logic   halted, halted_nxt;
    logic   aluop;

    assign aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                   (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

    // Phase and halted registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= halted_nxt;
        end
    end

    // Next phase: free-running wrap, except a sticky HLT parks the counter at OP_ADDR.
    always_comb begin
        state_nxt  = state;
        halted_nxt = halted;
        if (!halted) begin
            case (state)
                INST_ADDR:  state_nxt = INST_FETCH;
                INST_FETCH: state_nxt = INST_LOAD;
                INST_LOAD:  state_nxt = IDLE;
                IDLE:       state_nxt = OP_ADDR;
                OP_ADDR: begin
                    if (HALT_STICKY && bus.opcode == OP_HLT) begin
                        halted_nxt = 1'b1;
                        state_nxt  = OP_ADDR;
                    end else begin
                        state_nxt = OP_FETCH;
                    end
                end
                OP_FETCH:   state_nxt = ALU_OP;
                ALU_OP:     state_nxt = STORE;
                STORE:      state_nxt = INST_ADDR;
                default:    state_nxt = INST_ADDR;
            endcase
        end
    end

    // Per-phase strobe decode; once halted only halt stays high.
    always_comb begin
        bus.sel    = 1'b0;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.data_e = 1'b0;
        bus.halt   = 1'b0;
        if (halted) begin
            bus.halt = 1'b1;
        end else begin
            case (state)
                INST_ADDR: begin
                    bus.sel = 1'b1;
                end
                INST_FETCH: begin
                    bus.sel    = 1'b1;
                    bus.mem_rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    bus.sel    = 1'b1;
                    bus.mem_rd = 1'b1;
                    bus.ld_ir  = 1'b1;
                end
                OP_ADDR: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = (bus.opcode == OP_HLT);
                end
                OP_FETCH: begin
                    bus.mem_rd = aluop;
                end
                ALU_OP: begin
                    bus.mem_rd = aluop;
                    bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
                    bus.ld_pc  = (bus.opcode == OP_JMP);
                    bus.data_e = (bus.opcode == OP_STO);
                end
                STORE: begin
                    bus.mem_rd = aluop;
                    bus.ld_ac  = aluop;
                    bus.inc_pc = (bus.opcode == OP_JMP);
                    bus.ld_pc  = (bus.opcode == OP_JMP);
                    bus.mem_wr = (bus.opcode == OP_STO);
                    bus.data_e = (bus.opcode == OP_STO);
                end
                default: ;
            endcase
        end
    end

    assign bus.phase = state;
endmodule

// File: tb/tb_risc_sequencer.sv
// Bench for risc_sequencer: a sticky and a non-sticky instance run side by side
// against an instruction-level reference model, plus a small behavioural memory.
module tb_risc_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic [7:0] ac;
    logic [7:0] mem [32];
    localparam logic [4:0] ADDR = 5'b10101;

    int checks = 0;
    int errors = 0;
    int m_ph   [2];
    bit m_halt [2];

    risc_sequencer_if b0 ();
    risc_sequencer_if b1 ();

    assign b0.opcode = opcode;
    assign b0.zero   = zero;
    assign b1.opcode = opcode;
    assign b1.zero   = zero;

    risc_sequencer #(.HALT_STICKY(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
    risc_sequencer #(.HALT_STICKY(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

    always #5 clk = ~clk;

    // Behavioural 32x8 memory fed by the sticky instance; operand address is fixed.
    always @(posedge clk) begin
        if (b0.mem_wr) mem[ADDR] <= b0.data_e ? ac : 8'h00;
    end

    // Expected strobes {sel,mem_rd,mem_wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt}.
    function automatic logic [8:0] ref_out(int ph, bit hl, logic [2:0] op, logic z);
        bit alu, sto, jmp;
        logic [8:0] v;
        if (hl) return 9'b0_0000_0001;
        alu = (op >= 3'd2) && (op <= 3'd5);
        sto = (op == 3'd6);
        jmp = (op == 3'd7);
        v[8] = (ph < 4);
        v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        v[6] = (ph == 7) && sto;
        v[5] = (ph == 2) || (ph == 3);
        v[4] = (ph == 7) && alu;
        v[3] = (ph >= 6) && jmp;
        v[2] = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && jmp);
        v[1] = (ph >= 6) && sto;
        v[0] = (ph == 4) && (op == 3'd0);
        return v;
    endfunction

    task automatic check_dut(int k, string tag);
        logic [8:0] obs, exp;
        logic [2:0] ph;
        if (k == 0) begin
            obs = {b0.sel, b0.mem_rd, b0.mem_wr, b0.ld_ir, b0.ld_ac, b0.ld_pc, b0.inc_pc, b0.data_e, b0.halt};
            ph  = b0.phase;
        end else begin
            obs = {b1.sel, b1.mem_rd, b1.mem_wr, b1.ld_ir, b1.ld_ac, b1.ld_pc, b1.inc_pc, b1.data_e, b1.halt};
            ph  = b1.phase;
        end
        exp = ref_out(m_ph[k], m_halt[k], opcode, zero);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d strobes: got %b want %b (phase %0d op %0d)", tag, k, obs, exp, m_ph[k], opcode);
        end
        checks++;
        assert (ph === 3'(m_ph[k])) else begin
            errors++;
            $error("FAIL %s dut%0d phase: got %0d want %0d", tag, k, ph, m_ph[k]);
        end
        checks++;
        assert ((obs[7] & obs[6]) === 1'b0) else begin
            errors++;
            $error("FAIL %s dut%0d rd_wr_excl: got rd=%b wr=%b want not both", tag, k, obs[7], obs[6]);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k]   = 0;
            m_halt[k] = 1'b0;
        end
    endtask

    // One clock: advance the model at the edge, check both instances on the falling edge.
    task automatic cyc(string tag);
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (m_halt[k]) ;
                else if (m_ph[k] == 4 && opcode == 3'd0 && k == 0) m_halt[k] = 1'b1;
                else m_ph[k] = (m_ph[k] + 1) % 8;
            end
        end
        @(negedge clk);
        check_dut(0, tag);
        check_dut(1, tag);
    endtask

    task automatic run_instr(logic [2:0] op, logic z, string tag);
        opcode = op;
        zero   = z;
        repeat (8) cyc(tag);
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 3'd0;
        zero   = 1'b0;
        ac     = 8'h00;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        model_reset();

        // Held in reset: phase 0, only sel high.
        repeat (3) cyc("reset");
        checks++;
        assert ({b0.phase, b0.sel, b0.halt, b0.mem_rd} === 6'b000_1_0_0) else begin
            errors++;
            $error("FAIL reset_vals: got %b want 000100", {b0.phase, b0.sel, b0.halt, b0.mem_rd});
        end
        rst_n = 1'b1;

        // Directed instructions covering every decode branch.
        run_instr(3'd2, 1'b0, "add");
        run_instr(3'd1, 1'b1, "skz_z1");
        run_instr(3'd1, 1'b0, "skz_z0");
        run_instr(3'd7, 1'b0, "jmp");
        run_instr(3'd5, 1'b1, "lda");

        // Random non-halting instructions, zero toggled inside the instruction.
        for (int n = 0; n < 40; n++) begin
            opcode = 3'($urandom_range(1, 7));
            for (int c = 0; c < 8; c++) begin
                zero = 1'($urandom);
                cyc("rand");
            end
        end

        // STO writes AC to the addressed location; read it back.
        ac = 8'hAA;
        run_instr(3'd6, 1'b0, "sto");
        checks++;
        assert (mem[ADDR] === 8'hAA) else begin
            errors++;
            $error("FAIL sto_readback: got %h want aa", mem[ADDR]);
        end

        // HLT: sticky instance parks at phase 4, non-sticky keeps cycling.
        run_instr(3'd0, 1'b0, "hlt");
        for (int c = 0; c < 20; c++) begin
            zero = 1'($urandom);
            cyc("halted");
        end
        checks++;
        assert ({b0.phase, b0.halt, b0.inc_pc} === 5'b100_1_0) else begin
            errors++;
            $error("FAIL halt_hold: got %b want 10010", {b0.phase, b0.halt, b0.inc_pc});
        end

        // Reset pulse releases the halt immediately.
        rst_n = 1'b0;
        #1;
        model_reset();
        check_dut(0, "halt_rst");
        check_dut(1, "halt_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(3'd3, 1'b0, "after_rst");

        // Reset in phase 7 of STO kills the write before the edge.
        ac     = 8'h55;
        opcode = 3'd6;
        repeat (7) cyc("sto_abort");
        checks++;
        assert ({b0.mem_wr, b0.data_e} === 2'b11) else begin
            errors++;
            $error("FAIL sto_ph7: got %b want 11", {b0.mem_wr, b0.data_e});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert ({b0.mem_wr, b0.data_e, b0.sel, b0.phase} === 6'b0_0_1_000) else begin
            errors++;
            $error("FAIL async_rst: got %b want 001000", {b0.mem_wr, b0.data_e, b0.sel, b0.phase});
        end
        model_reset();
        cyc("in_rst");
        checks++;
        assert (mem[ADDR] === 8'hAA) else begin
            errors++;
            $error("FAIL no_partial_write: got %h want aa", mem[ADDR]);
        end
        rst_n = 1'b1;
        run_instr(3'd4, 1'b1, "final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/risc_sequencer.md
# risc_sequencer

Eight-phase instruction sequencer for the VeriRISC core. It drives the `rd`/`wr` strobes of the 32x8 `memory` block, the address-select mux, the IR/AC/PC load enables and the bus-drive enable. It walks a fixed fetch/execute phase cycle and decodes the current opcode and the accumulator-zero flag into per-phase control strobes. It sits directly upstream of `memory`: its `mem_rd`/`mem_wr` connect to the memory's `rd`/`wr` ports.

## Interface
- `HALT_STICKY`, default 1. 1: HLT freezes the sequencer until reset. 0: `halt` pulses for one phase and the cycle continues.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  3  current instruction opcode from IR: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `zero`  in  1  accumulator-is-zero flag.
- `sel`  out  1  address mux: 1 = PC, 0 = IR operand.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `ld_ir`  out  1  instruction register load.
- `ld_ac`  out  1  accumulator load.
- `ld_pc`  out  1  program counter load (jump).
- `inc_pc`  out  1  program counter increment.
- `data_e`  out  1  enables the accumulator onto the memory data bus.
- `halt`  out  1  processor halted.
- `phase`  out  3  current phase, for debug and bench visibility.

## Operation
- State: 3-bit `phase` counter plus a `halted` flag. Both are cleared asynchronously by `rst_n`=0.
- Phases in order:
  - 0 INST_ADDR
  - 1 INST_FETCH
  - 2 INST_LOAD
  - 3 IDLE
  - 4 OP_ADDR
  - 5 OP_FETCH
  - 6 ALU_OP
  - 7 STORE
- `phase` advances by 1 each clock and wraps 7 -> 0.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Outputs are decoded combinationally from registered `phase`/`halted` and the current `opcode`/`zero`. Any output not listed for a phase is 0.
  - Phase 0: `sel`.
  - Phase 1: `sel`, `mem_rd`.
  - Phase 2: `sel`, `mem_rd`, `ld_ir`.
  - Phase 3: `sel`, `mem_rd`, `ld_ir`.
  - Phase 4: `inc_pc`; `halt` = (opcode==HLT).
  - Phase 5: `mem_rd` = ALUOP.
  - Phase 6: `mem_rd` = ALUOP; `inc_pc` = (SKZ && zero); `ld_pc` = JMP; `data_e` = STO.
  - Phase 7: `mem_rd` = ALUOP; `ld_ac` = ALUOP; `inc_pc` = JMP; `ld_pc` = JMP; `mem_wr` = STO; `data_e` = STO.
- `mem_rd` and `mem_wr` are never both 1. This is guaranteed by the decode table and is a bench assertion.
- HLT, `HALT_STICKY`=1:
  - On the clock edge that leaves phase 4 with opcode==HLT, `halted` sets and `phase` stays at 4.
  - While halted: `halt`=1 and every other strobe is 0, including `inc_pc`. `phase` holds 4.
  - Only `rst_n` clears `halted`.
- HLT, `HALT_STICKY`=0: `halt` is asserted only during phase 4, `halted` never sets, and sequencing continues.
- `opcode` is sampled every cycle with no latching inside the block. IR updates only while `ld_ir`=1 (phases 2–3), so `opcode` is stable from phase 4 through phase 7.

## Timing
- Reset values while `rst_n`=0:
  - `phase`=0, `halted`=0.
  - `sel`=1; `mem_rd`, `mem_wr`, `ld_ir`, `ld_ac`, `ld_pc`, `inc_pc`, `data_e`, `halt` all 0.
- Reset deassertion: the first rising edge after `rst_n` rises moves `phase` 0 -> 1. One instruction takes exactly 8 clocks.
- Reset asserted mid-instruction, including during phase 7 with `mem_wr`=1: outputs drop to reset values immediately (asynchronous). No partial write is issued after reset asserts.
- Memory write: `mem_wr` and `data_e` are high together for the whole of phase 7. The address (`sel`=0) and data are stable one phase earlier, since `data_e` is already high in phase 6.
- Memory read: `mem_rd` is high for two consecutive phases (1–2 or 5–6) before the consuming load (`ld_ir` in phase 2/3, `ld_ac` in phase 7).
- `zero` is only consumed in phase 6. It must be stable during that phase.
- Wrap: phase 7 -> 0 with no bubble cycle.

## Test plan
- Reset then ADD (opcode=2), 8 clocks -> `phase` sequence 0..7.
  - `mem_rd`=1 in phases 1,2,3,5,6,7.
  - `ld_ac`=1 only in phase 7.
  - `mem_wr`=0 throughout.
- STO (opcode=6) -> `data_e`=1 in phases 6–7 and `mem_wr`=1 in phase 7 only. Drive a real `memory` with address 5'b10101 and AC=8'hAA, then read back -> 8'hAA.
- SKZ (opcode=1):
  - `zero`=1 -> `inc_pc`=1 in phases 4 and 6.
  - `zero`=0 -> `inc_pc`=1 in phase 4 only.
- JMP (opcode=7) -> `ld_pc`=1 in phases 6–7, `inc_pc`=1 in phases 4 and 7, `mem_rd`=0 in phases 5–7.
- HLT (opcode=0), `HALT_STICKY`=1 -> `halt` rises in phase 4, `phase` stays 4 for 20 further clocks, all other strobes 0. Pulse `rst_n` low -> `phase`=0, `halt`=0, `sel`=1.
- Assert `rst_n`=0 asynchronously mid-phase 7 of STO -> `mem_wr` and `data_e` fall before the next clock edge. Addressed memory contents are unchanged if reset precedes the write edge.
